// File: rtl/max_pool_stream.sv
// rtl/max_pool_stream.sv - streaming signed max pooling (stride = window) with optional ReLU
module max_pool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int POOL       = 2,
  parameter int RELU_EN    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  localparam int OW = IMG_W / POOL;
  localparam int OH = IMG_H / POOL;
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int PW = $clog2(POOL);
  localparam int XW = (OW > 1) ? $clog2(OW) : 1;
  localparam int YW = (OH > 1) ? $clog2(OH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_USED = CW'(OW * POOL);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_USED = RW'(OH * POOL);
  localparam logic [PW-1:0] PH_LAST  = PW'(POOL - 1);
  localparam logic [XW-1:0] WX_LAST  = XW'(OW - 1);
  localparam logic [YW-1:0] WY_LAST  = YW'(OH - 1);

  // Raster position plus in-window phase and window index, so no divides are needed.
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] cph, rph;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;

  logic signed [DATA_WIDTH-1:0] hmax, hnext, vmax, res;
  logic signed [DATA_WIDTH-1:0] lb [OW];
  logic accept, in_win, win_end, col_wrap;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // A held result blocks intake until downstream takes it.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_win   = (col < COL_USED) && (row < ROW_USED);
  assign col_wrap = (col == COL_LAST);
  assign win_end  = accept && in_win && (cph == PH_LAST);

  // Horizontal max of the current window row, then merge with the line-buffer partial.
  always_comb begin
    hnext = (cph == '0) ? in_data : smax(hmax, in_data);
    vmax  = (rph == '0) ? hnext : smax(lb[wx], hnext);
    res   = vmax;
    if ((RELU_EN != 0) && vmax[DATA_WIDTH-1]) res = '0;
  end

  // Position counters and horizontal running max advance on accepted pixels only.
  always_ff @(posedge clk) begin
    if (reset) begin
      col  <= '0;
      row  <= '0;
      cph  <= '0;
      rph  <= '0;
      wx   <= '0;
      wy   <= '0;
      hmax <= '0;
    end else if (accept) begin
      hmax <= hnext;
      if (col_wrap) begin
        col <= '0;
        cph <= '0;
        wx  <= '0;
        if (row == ROW_LAST) begin
          row <= '0;
          rph <= '0;
          wy  <= '0;
        end else begin
          row <= row + 1'b1;
          if (rph == PH_LAST) begin
            rph <= '0;
            wy  <= wy + 1'b1;
          end else begin
            rph <= rph + 1'b1;
          end
        end
      end else begin
        col <= col + 1'b1;
        if (cph == PH_LAST) begin
          cph <= '0;
          wx  <= wx + 1'b1;
        end else begin
          cph <= cph + 1'b1;
        end
      end
    end
  end

  // Partial column maxima; the final window row goes straight to the output instead.
  always_ff @(posedge clk) begin
    if (win_end && (rph != PH_LAST)) lb[wx] <= vmax;
  end

  // Output register: load on a completed window, otherwise drop after a handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (win_end && (rph == PH_LAST)) begin
      out_data  <= res;
      out_valid <= 1'b1;
      out_last  <= (wy == WY_LAST) && (wx == WX_LAST);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// tb/tb_max_pool_stream.sv - scoreboard bench for max_pool_stream in four configurations
module tb_max_pool_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int n28 = 0, n4 = 0, n4r = 0, n5 = 0;

  logic [16:0] q28[$], q4[$], q4r[$], q5[$];
  logic [16:0] e28, e4, e4r, e5;

  logic [15:0] i28_d = '0; logic i28_v = 1'b0, o28_r = 1'b1;
  logic [15:0] d28; logic rdy28, v28, l28;
  logic [15:0] i4_d = '0;  logic i4_v = 1'b0, o4_r = 1'b1;
  logic [15:0] d4, d4r; logic rdy4, v4, l4, rdy4r, v4r, l4r;
  logic [15:0] i5_d = '0;  logic i5_v = 1'b0, o5_r = 1'b1;
  logic [15:0] d5; logic rdy5, v5, l5;

  max_pool_stream u28 (
    .clk(clk), .reset(reset), .in_data(i28_d), .in_valid(i28_v), .in_ready(rdy28),
    .out_data(d28), .out_valid(v28), .out_ready(o28_r), .out_last(l28));

  max_pool_stream #(.IMG_W(4), .IMG_H(4), .POOL(2)) u4 (
    .clk(clk), .reset(reset), .in_data(i4_d), .in_valid(i4_v), .in_ready(rdy4),
    .out_data(d4), .out_valid(v4), .out_ready(o4_r), .out_last(l4));

  max_pool_stream #(.IMG_W(4), .IMG_H(4), .POOL(2), .RELU_EN(1)) u4r (
    .clk(clk), .reset(reset), .in_data(i4_d), .in_valid(i4_v), .in_ready(rdy4r),
    .out_data(d4r), .out_valid(v4r), .out_ready(o4_r), .out_last(l4r));

  max_pool_stream #(.IMG_W(5), .IMG_H(5), .POOL(2)) u5 (
    .clk(clk), .reset(reset), .in_data(i5_d), .in_valid(i5_v), .in_ready(rdy5),
    .out_data(d5), .out_valid(v5), .out_ready(o5_r), .out_last(l5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitors: a transfer is seen between edges with valid && ready.
  always begin
    @(negedge clk); #2;
    if (v28 && o28_r) begin
      n28++;
      chk("q28_nonempty", 32'(q28.size() != 0), 1);
      if (q28.size() != 0) begin
        e28 = q28.pop_front();
        chk("d28", d28, e28[15:0]);
        chk("l28", l28, e28[16]);
      end
    end
  end

  always begin
    @(negedge clk); #2;
    if (v4 && o4_r) begin
      n4++;
      chk("q4_nonempty", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        chk("d4", d4, e4[15:0]);
        chk("l4", l4, e4[16]);
      end
    end
  end

  always begin
    @(negedge clk); #2;
    if (v4r && o4_r) begin
      n4r++;
      chk("q4r_nonempty", 32'(q4r.size() != 0), 1);
      if (q4r.size() != 0) begin
        e4r = q4r.pop_front();
        chk("d4r", d4r, e4r[15:0]);
        chk("l4r", l4r, e4r[16]);
      end
    end
  end

  always begin
    @(negedge clk); #2;
    if (v5 && o5_r) begin
      n5++;
      chk("q5_nonempty", 32'(q5.size() != 0), 1);
      if (q5.size() != 0) begin
        e5 = q5.pop_front();
        chk("d5", d5, e5[15:0]);
        chk("l5", l5, e5[16]);
      end
    end
  end

  task automatic send28(input logic [15:0] v);
    bit done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk); i28_d = v; i28_v = 1'b1; #1;
      done = rdy28;
      @(posedge clk);
    end
    if (!done) begin
      n_fail++;
      $display("FAIL send28_timeout: pixel %0d not accepted", v);
    end
  endtask

  task automatic send4(input logic [15:0] v);
    bit done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk); i4_d = v; i4_v = 1'b1; #1;
      done = rdy4 && rdy4r;
      @(posedge clk);
    end
    if (!done) begin
      n_fail++;
      $display("FAIL send4_timeout: pixel %0d not accepted", v);
    end
  endtask

  task automatic send5(input logic [15:0] v);
    bit done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk); i5_d = v; i5_v = 1'b1; #1;
      done = rdy5;
      @(posedge clk);
    end
    if (!done) begin
      n_fail++;
      $display("FAIL send5_timeout: pixel %0d not accepted", v);
    end
  endtask

  // Ten cycles of downstream stall while a pixel is offered; result must freeze.
  task automatic stall28(input logic [15:0] v);
    logic [15:0] held;
    @(negedge clk); o28_r = 1'b0; i28_d = v; i28_v = 1'b1; #1;
    held = d28;
    chk("bp_valid_at_stall", v28, 1);
    chk("bp_held_value", held, 32'(v - 16'd1));
    for (int k = 0; k < 10; k++) begin
      chk("bp_in_ready", rdy28, 0);
      chk("bp_out_valid", v28, 1);
      chk("bp_data_stable", d28, held);
      @(negedge clk); #1;
    end
    o28_r = 1'b1; i28_v = 1'b0;
  endtask

  // Increasing raster pattern: each window's max is its bottom-right pixel.
  task automatic frame28(input int npix, input int base, input int stall_at);
    for (int i = 0; i < npix; i++) begin
      int r;
      int c;
      logic [15:0] v;
      r = i / 28;
      c = i % 28;
      v = 16'(base + i);
      if (i == stall_at) stall28(v);
      if ((r % 2 == 1) && (c % 2 == 1)) q28.push_back({(r == 27 && c == 27), v});
      send28(v);
    end
    @(negedge clk); i28_v = 1'b0;
  endtask

  task automatic frame4();
    int a4[16] = '{-5, -3, -8, -1, -7, -2, -4, -6, 1, -9, 0, 0, -1, -1, 0, -2};
    int x4[4]  = '{-2, -1, 1, 0};
    int x4r[4] = '{0, 0, 1, 0};
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
        q4.push_back({(k == 3), 16'(x4[k])});
        q4r.push_back({(k == 3), 16'(x4r[k])});
        k++;
      end
      send4(16'(a4[i]));
    end
    @(negedge clk); i4_v = 1'b0;
  endtask

  task automatic frame5();
    for (int i = 0; i < 25; i++) begin
      int r;
      int c;
      r = i / 5;
      c = i % 5;
      if (r < 4 && c < 4 && (r % 2 == 1) && (c % 2 == 1))
        q5.push_back({(r == 3 && c == 3), 16'(r * 5 + c)});
      send5((r == 4 || c == 4) ? 16'd32767 : 16'(r * 5 + c));
    end
    @(negedge clk); i5_v = 1'b0;
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 50 && (q28.size() + q4.size() + q4r.size() + q5.size()) != 0; t++)
      @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag, input logic rdy, input logic v, input logic l,
                           input logic [15:0] d);
    chk({tag, "_in_ready"}, rdy, 1);
    chk({tag, "_out_valid"}, v, 0);
    chk({tag, "_out_last"}, l, 0);
    chk({tag, "_out_data"}, d, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    chk_reset("rst28", rdy28, v28, l28, d28);
    chk_reset("rst4", rdy4, v4, l4, d4);
    chk_reset("rst4r", rdy4r, v4r, l4r, d4r);
    chk_reset("rst5", rdy5, v5, l5, d5);

    // Full default frame, free-flowing output.
    n28 = 0;
    frame28(784, 0, -1);
    wait_empty();
    chk("f1_q28_empty", q28.size(), 0);
    chk("f1_count", n28, 196);

    // Same frame with a ten-cycle downstream stall mid-frame.
    n28 = 0;
    frame28(784, 0, 100);
    wait_empty();
    chk("bp_q28_empty", q28.size(), 0);
    chk("bp_count", n28, 196);

    // Partial frame, reset, then a fresh full frame.
    n28 = 0;
    frame28(40, 5000, -1);
    wait_empty();
    chk("pre_rst_count", n28, 6);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    chk_reset("mid_rst28", rdy28, v28, l28, d28);
    n28 = 0;
    frame28(784, 0, -1);
    wait_empty();
    chk("post_rst_q28_empty", q28.size(), 0);
    chk("post_rst_count", n28, 196);

    // Signed 4x4 frames, plain and with ReLU, two back to back.
    n4 = 0; n4r = 0;
    frame4();
    frame4();
    wait_empty();
    chk("f4_count", n4, 8);
    chk("f4r_count", n4r, 8);
    chk("f4_q_empty", q4.size() + q4r.size(), 0);

    // 5x5 frames: trailing column and row must be discarded.
    n5 = 0;
    frame5();
    frame5();
    wait_empty();
    chk("f5_count", n5, 8);
    chk("f5_q_empty", q5.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/max_pool_stream.md
MAX_POOL_STREAM -- requirements
Module: max_pool_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the signed two's-complement sample width.
REQ-002 Parameter IMG_W, default 28, is the input feature-map width in pixels.
REQ-003 Parameter IMG_H, default 28, is the input feature-map height in pixels.
REQ-004 Parameter POOL, default 2, range 2..4, is the square window size; stride equals POOL.
REQ-005 Parameter RELU_EN, default 0; when 1, outputs below zero SHALL be replaced by 0.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port in_data, input, DATA_WIDTH bits: pixel in raster order, row-major, one frame of IMG_W*IMG_H pixels.
REQ-009 Port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-010 Port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-011 Port out_data, output, DATA_WIDTH bits: pooled maximum, signed.
REQ-012 Port out_valid, output, 1 bit: out_data is valid.
REQ-013 Port out_ready, input, 1 bit: downstream accepts out_data.
REQ-014 Port out_last, output, 1 bit: qualifies the final pooled output of a frame.

Function
REQ-015 A pixel SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-016 in_ready SHALL be combinationally (!out_valid || out_ready).
REQ-017 The block SHALL keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1), both advancing only on accepted pixels; the column wraps to 0 and increments the row; the row wraps to 0 after the last pixel of a frame.
REQ-018 The windowed region SHALL be the top-left OW = floor(IMG_W/POOL) by OH = floor(IMG_H/POOL) windows; pixels in trailing columns (col >= OW*POOL) or trailing rows (row >= OH*POOL) SHALL be accepted and discarded without affecting any output.
REQ-019 The block SHALL keep a horizontal running-maximum register: loaded with the pixel when col%POOL==0, otherwise updated to the signed max of itself and the pixel.
REQ-020 The block SHALL keep a line buffer of OW partial-maximum entries, each DATA_WIDTH bits.
REQ-021 On the pixel with col%POOL==POOL-1, the window's horizontal max H SHALL be written to entry col/POOL when row%POOL==0, otherwise the entry SHALL become signed max(entry, H).
REQ-022 When row%POOL==POOL-1 on that pixel, the final max(entry, H), after optional ReLU, SHALL be registered onto out_data with out_valid=1 on the next rising edge; the entry need not be written.
REQ-023 Latency SHALL be exactly one clock from acceptance of a window's last pixel to out_valid assertion.
REQ-024 All comparisons SHALL be signed; on ties either operand is acceptable, as the values are equal.
REQ-025 out_data, out_valid and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 out_valid SHALL clear on the edge where out_valid && out_ready, unless a new result is registered on that same edge, in which case out_valid remains 1 with the new data.
REQ-027 out_last SHALL be 1 with the output of window (OH-1, OW-1) and 0 otherwise.
REQ-028 Outputs SHALL appear in raster order of windows, OW*OH per frame, with no gaps or duplicates across back-to-back frames.

Reset
REQ-029 While reset=1 on a rising edge: counters SHALL be set to 0, the horizontal register to 0, out_valid to 0, out_last to 0 and out_data to 0; line-buffer contents need not be cleared.
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame; the first pixel accepted after reset SHALL be treated as (row 0, col 0).
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 The bench SHALL check: with defaults, a 28x28 frame with pixel=row*28+col and out_ready=1 -> 196 outputs, first output 29, last output 783 with out_last=1.
REQ-033 The bench SHALL check: with IMG_W=IMG_H=4 and POOL=2, rows {-5,-3,-8,-1},{-7,-2,-4,-6},{1,-9,0,0},{-1,-1,0,-2} -> outputs -2, -1, 1, 0, and out_last accompanies the 0.
REQ-034 The bench SHALL check: the same 4x4 stimulus with RELU_EN=1 -> outputs 0, 0, 1, 0.
REQ-035 The bench SHALL check: with IMG_W=IMG_H=5, POOL=2 and a full frame of 25 pixels -> exactly 4 outputs, and column 4 and row 4 values (set to 32767) never appear in the output.
REQ-036 The bench SHALL check backpressure: out_ready held 0 for 10 cycles with in_valid=1 -> in_ready=0 while out_valid=1, out_data stable, and no pixel lost; after out_ready rises the output sequence matches REQ-032.
REQ-037 The bench SHALL check: reset pulsed after 40 pixels of a 28x28 frame, then a full fresh frame -> exactly 196 outputs matching REQ-032, with none derived from the pre-reset pixels.
